rvh_pmp_check_arb: RTL and testbench

// Requester-side front end for the PMP permission-check port. It arbitrates check requests from
// REQ_COUNT clients (e.g. fetch, load, store) round-robin and drives one check per cycle into the PMP.
// It tracks in-flight checks across the PMP latency, captures the fail result, and returns

---
 rtl/rvh_pmp_check_arb.sv | 218 +++++++++++++++++++++
 tb/tb_rvh_pmp_check_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rvh_pmp_check_arb.sv
// Requester-side front end for the PMP check port: round-robin arbitration over
// REQ_COUNT clients, an in-flight pipe covering the PMP latency, and an in-order
// response FIFO whose occupancy plus in-flight checks never exceeds RESP_DEPTH.
module rvh_pmp_check_arb #(
  parameter int unsigned REQ_COUNT     = 3,
  parameter int unsigned PADDR_WIDTH   = 56,
  parameter int unsigned CHECK_LATENCY = 1,
  parameter int unsigned RESP_DEPTH    = 2,
  parameter int unsigned ID_WIDTH      = $clog2(REQ_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [REQ_COUNT-1:0]             req_vld_i,
  input  logic [REQ_COUNT*PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [REQ_COUNT*2-1:0]           req_access_type_i,
  output logic [REQ_COUNT-1:0]             req_rdy_o,
  output logic                             pmp_check_vld_o,
  output logic [PADDR_WIDTH-1:0]           pmp_check_paddr_o,
  output logic [1:0]                       pmp_check_access_type_o,
  input  logic                             pmp_check_fail_i,
  output logic                             resp_vld_o,
  output logic [ID_WIDTH-1:0]              resp_id_o,
  output logic                             resp_fail_o,
  input  logic                             resp_rdy_i
);

  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + CHECK_LATENCY + 1);
  localparam int unsigned SUM_W = ID_WIDTH + 1;

  logic [PADDR_WIDTH-1:0] paddr_arr [REQ_COUNT];
  logic [1:0]             atype_arr [REQ_COUNT];

  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic                   grant_vld;
  logic [ID_WIDTH-1:0]    grant_id;
  logic                   can_issue;
  logic                   deq;
  logic                   enq;
  logic                   enq_vld;
  logic [ID_WIDTH-1:0]    enq_id;
  logic [CNT_W-1:0]       inflight_cnt;
  logic [CNT_W-1:0]       credit_used;

  logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ID_WIDTH-1:0]    id_mem_q   [RESP_DEPTH];
  logic [ID_WIDTH-1:0]    id_mem_d   [RESP_DEPTH];
  logic                   fail_mem_q [RESP_DEPTH];
  logic                   fail_mem_d [RESP_DEPTH];

  // Unpack the flat per-client request buses
  for (genvar g = 0; g < REQ_COUNT; g++) begin : g_unpack
    assign paddr_arr[g] = req_paddr_i[g*PADDR_WIDTH +: PADDR_WIDTH];
    assign atype_arr[g] = req_access_type_i[g*2 +: 2];
  end

  // Credit check and round-robin search starting at rr_ptr
  always_comb begin
    logic [SUM_W-1:0]    sum;
    logic [ID_WIDTH-1:0] idx;
    sum         = '0;
    idx         = '0;
    grant_vld   = 1'b0;
    grant_id    = '0;
    deq         = resp_vld_o & resp_rdy_i;
    credit_used = fifo_cnt_q + inflight_cnt - CNT_W'(deq);
    // Reset gating keeps pending clients ungranted while rst is held
    can_issue   = !rst && !flush_i && (credit_used < CNT_W'(RESP_DEPTH));
    for (int unsigned k = 0; k < REQ_COUNT; k++) begin
      sum = SUM_W'(rr_ptr_q) + SUM_W'(k);
      if (sum >= SUM_W'(REQ_COUNT)) begin
        sum = sum - SUM_W'(REQ_COUNT);
      end
      idx = ID_WIDTH'(sum);
      if (can_issue && !grant_vld && req_vld_i[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // Grant one-hot, PMP drive, and pointer advance past the winner
  always_comb begin
    logic [SUM_W-1:0] nxt;
    req_rdy_o = '0;
    rr_ptr_d  = rr_ptr_q;
    nxt       = '0;
    if (grant_vld) begin
      req_rdy_o[grant_id] = 1'b1;
      nxt = SUM_W'(grant_id) + SUM_W'(1);
      if (nxt >= SUM_W'(REQ_COUNT)) begin
        nxt = '0;
      end
      rr_ptr_d = ID_WIDTH'(nxt);
    end
  end

  assign pmp_check_vld_o         = grant_vld;
  assign pmp_check_paddr_o       = grant_vld ? paddr_arr[grant_id] : '0;
  assign pmp_check_access_type_o = grant_vld ? atype_arr[grant_id] : 2'b00;

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  if (CHECK_LATENCY == 0) begin : g_comb
    assign enq_vld      = grant_vld;
    assign enq_id       = grant_id;
    assign inflight_cnt = '0;
  end else begin : g_pipe
    logic [CHECK_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ID_WIDTH-1:0]      pipe_id_q [CHECK_LATENCY];
    logic [ID_WIDTH-1:0]      pipe_id_d [CHECK_LATENCY];

    // Shift {vld,id} along the PMP latency; flush kills every stage
    always_comb begin
      pipe_vld_d = '0;
      for (int unsigned s = 0; s < CHECK_LATENCY; s++) begin
        pipe_id_d[s] = '0;
      end
      pipe_vld_d[0] = grant_vld;
      pipe_id_d[0]  = grant_id;
      for (int unsigned s = 1; s < CHECK_LATENCY; s++) begin
        pipe_vld_d[s] = pipe_vld_q[s-1];
        pipe_id_d[s]  = pipe_id_q[s-1];
      end
      if (flush_i) begin
        pipe_vld_d = '0;
      end
    end

    // Count checks still waiting on the PMP result
    always_comb begin
      inflight_cnt = '0;
      for (int unsigned s = 0; s < CHECK_LATENCY; s++) begin
        inflight_cnt = inflight_cnt + CNT_W'(pipe_vld_q[s]);
      end
    end

    // In-flight pipe registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_vld_q <= '0;
        pipe_id_q  <= '{default: '0};
      end else begin
        pipe_vld_q <= pipe_vld_d;
        pipe_id_q  <= pipe_id_d;
      end
    end

    assign enq_vld = pipe_vld_q[CHECK_LATENCY-1];
    assign enq_id  = pipe_id_q[CHECK_LATENCY-1];
  end

  // A result returning during flush belongs to a killed check
  assign enq = enq_vld & !flush_i;

  // Response FIFO next-state: push PMP result, pop on handshake, flush empties
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    id_mem_d   = id_mem_q;
    fail_mem_d = fail_mem_q;
    if (flush_i) begin
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (enq) begin
        id_mem_d[wr_ptr_q]   = enq_id;
        fail_mem_d[wr_ptr_q] = pmp_check_fail_i;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Response FIFO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      id_mem_q   <= '{default: '0};
      fail_mem_q <= '{default: 1'b0};
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      id_mem_q   <= id_mem_d;
      fail_mem_q <= fail_mem_d;
    end
  end

  assign resp_vld_o  = (fifo_cnt_q != '0);
  assign resp_id_o   = id_mem_q[rd_ptr_q];
  assign resp_fail_o = fail_mem_q[rd_ptr_q];

  a_fifo_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt_q <= CNT_W'(RESP_DEPTH));
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_rdy_o));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(enq && !deq && (fifo_cnt_q == CNT_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_rvh_pmp_check_arb.sv
// Bench for rvh_pmp_check_arb: cycle vectors with expected grants and response
// valid, plus a response scoreboard filled from the expected grants.
module tb_rvh_pmp_check_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned PW   = 56;
  localparam int unsigned NV   = 25;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [NREQ-1:0]  req_vld;
  logic [NREQ*PW-1:0] req_paddr;
  logic [NREQ*2-1:0]  req_atype;
  logic [NREQ-1:0]  req_rdy_o;
  logic             pmp_vld_o;
  logic [PW-1:0]    pmp_paddr_o;
  logic [1:0]       pmp_atype_o;
  logic             pmp_fail;
  logic             resp_vld_o;
  logic [1:0]       resp_id_o;
  logic             resp_fail_o;
  logic             resp_rdy;

  rvh_pmp_check_arb dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush_i                 (flush),
    .req_vld_i               (req_vld),
    .req_paddr_i             (req_paddr),
    .req_access_type_i       (req_atype),
    .req_rdy_o               (req_rdy_o),
    .pmp_check_vld_o         (pmp_vld_o),
    .pmp_check_paddr_o       (pmp_paddr_o),
    .pmp_check_access_type_o (pmp_atype_o),
    .pmp_check_fail_i        (pmp_fail),
    .resp_vld_o              (resp_vld_o),
    .resp_id_o               (resp_id_o),
    .resp_fail_o             (resp_fail_o),
    .resp_rdy_i              (resp_rdy)
  );

  typedef struct {
    logic [2:0] vld;
    logic       rrdy;
    logic       fail;      // PMP result for this cycle's grant, returned next cycle
    logic       flush;
    logic [2:0] exp_rdy;
    logic       exp_rvld;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic       fail;
  } rsp_t;

  vec_t          vecs [NV];
  rsp_t          sb [$];
  logic [PW-1:0] exp_paddr [NREQ];
  int            n_cmp = 0;
  int            n_err = 0;
  logic          prev_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [2:0] vld, input logic rrdy, input logic fail,
                      input logic fl, input logic [2:0] exp_rdy, input logic exp_rvld);
    vecs[i] = '{vld, rrdy, fail, fl, exp_rdy, exp_rvld};
  endtask

  function automatic logic [1:0] oh2id(input logic [2:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 3; k++) if (oh[k]) r = 2'(k);
    return r;
  endfunction

  initial begin
    rsp_t       e;
    logic [1:0] gid;

    for (int c = 0; c < int'(NREQ); c++) begin
      exp_paddr[c] = 56'h4000_0000 + 56'(c) * 56'h4000_0000;
      req_paddr[c*PW +: PW] = exp_paddr[c];
      req_atype[c*2 +: 2]   = 2'(c);
    end

    //       i   vld   rrdy fail flush exp_rdy rvld
    setv( 0, 3'b010, 1, 0, 0, 3'b010, 0);  // single request, client1
    setv( 1, 3'b000, 1, 0, 0, 3'b000, 0);
    setv( 2, 3'b000, 1, 0, 0, 3'b000, 1);  // response two cycles after grant
    setv( 3, 3'b111, 1, 1, 0, 3'b100, 0);  // round robin from ptr=2; client2 fails
    setv( 4, 3'b111, 1, 0, 0, 3'b001, 0);
    setv( 5, 3'b111, 1, 0, 0, 3'b010, 1);
    setv( 6, 3'b111, 1, 0, 0, 3'b100, 1);
    setv( 7, 3'b111, 1, 0, 0, 3'b001, 1);
    setv( 8, 3'b111, 1, 0, 0, 3'b010, 1);
    setv( 9, 3'b000, 1, 0, 0, 3'b000, 1);  // drain
    setv(10, 3'b000, 1, 0, 0, 3'b000, 1);
    setv(11, 3'b000, 1, 0, 0, 3'b000, 0);
    setv(12, 3'b111, 0, 0, 0, 3'b100, 0);  // backpressure: two grants only
    setv(13, 3'b111, 0, 0, 0, 3'b001, 0);
    setv(14, 3'b111, 0, 0, 0, 3'b000, 1);
    setv(15, 3'b111, 0, 0, 0, 3'b000, 1);
    setv(16, 3'b111, 1, 0, 0, 3'b010, 1);  // one dequeue frees one credit
    setv(17, 3'b111, 0, 0, 0, 3'b000, 1);
    setv(18, 3'b111, 0, 0, 0, 3'b000, 1);
    setv(19, 3'b111, 1, 1, 0, 3'b100, 1);  // grant whose fail lands during flush
    setv(20, 3'b111, 0, 0, 1, 3'b000, 1);  // flush: no grant
    setv(21, 3'b111, 1, 0, 0, 3'b001, 0);  // empty after flush, ptr unchanged
    setv(22, 3'b000, 1, 0, 0, 3'b000, 0);
    setv(23, 3'b000, 1, 0, 0, 3'b000, 1);
    setv(24, 3'b000, 1, 0, 0, 3'b000, 0);

    // Reset: pending requests must not be granted while rst is held
    rst       = 1'b1;
    flush     = 1'b0;
    req_vld   = 3'b111;
    pmp_fail  = 1'b0;
    resp_rdy  = 1'b0;
    prev_fail = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_rdy", 64'(req_rdy_o), 64'd0);
    check("reset pmp_vld", 64'(pmp_vld_o), 64'd0);
    check("reset resp_vld", 64'(resp_vld_o), 64'd0);
    req_vld = 3'b000;
    rst     = 1'b0;

    for (int i = 0; i < int'(NV); i++) begin
      @(posedge clk);
      #1;
      req_vld   = vecs[i].vld;
      resp_rdy  = vecs[i].rrdy;
      flush     = vecs[i].flush;
      pmp_fail  = prev_fail;
      prev_fail = vecs[i].fail;
      @(negedge clk);
      check($sformatf("v%0d req_rdy", i), 64'(req_rdy_o), 64'(vecs[i].exp_rdy));
      check($sformatf("v%0d pmp_vld", i), 64'(pmp_vld_o), 64'(vecs[i].exp_rdy != 3'b000));
      check($sformatf("v%0d resp_vld", i), 64'(resp_vld_o), 64'(vecs[i].exp_rvld));
      if (vecs[i].exp_rdy != 3'b000) begin
        gid = oh2id(vecs[i].exp_rdy);
        check($sformatf("v%0d pmp_paddr", i), 64'(pmp_paddr_o), 64'(exp_paddr[gid]));
        check($sformatf("v%0d pmp_atype", i), 64'(pmp_atype_o), 64'(gid));
      end else begin
        check($sformatf("v%0d idle paddr", i), 64'(pmp_paddr_o), 64'd0);
      end
      if (vecs[i].exp_rvld && vecs[i].rrdy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL v%0d resp: got id %0d with no response expected", i, resp_id_o);
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d resp_id", i), 64'(resp_id_o), 64'(e.id));
          check($sformatf("v%0d resp_fail", i), 64'(resp_fail_o), 64'(e.fail));
        end
      end
      if (vecs[i].exp_rdy != 3'b000) sb.push_back('{oh2id(vecs[i].exp_rdy), vecs[i].fail});
      if (vecs[i].flush) sb.delete();
    end

    // Async reset mid-stream: build up one queued and one in-flight check
    @(posedge clk); #1;
    req_vld  = 3'b111;
    resp_rdy = 1'b0;
    flush    = 1'b0;
    pmp_fail = 1'b0;
    @(negedge clk);
    check("pre-reset grant1", 64'(req_rdy_o), 64'b010);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre-reset grant2", 64'(req_rdy_o), 64'b100);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre-reset stall", 64'(req_rdy_o), 64'b000);
    check("pre-reset resp_vld", 64'(resp_vld_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst resp_vld", 64'(resp_vld_o), 64'd0);
    check("async rst pmp_vld", 64'(pmp_vld_o), 64'd0);
    check("async rst req_rdy", 64'(req_rdy_o), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    check("held rst req_rdy", 64'(req_rdy_o), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("post-rst grant", 64'(req_rdy_o), 64'b001);
    check("post-rst paddr", 64'(pmp_paddr_o), 64'(exp_paddr[0]));
    @(posedge clk); #1;
    req_vld = 3'b000;
    @(negedge clk);
    check("post-rst resp_vld early", 64'(resp_vld_o), 64'd0);
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("post-rst resp_vld", 64'(resp_vld_o), 64'd1);
    check("post-rst resp_id", 64'(resp_id_o), 64'd0);
    check("post-rst resp_fail", 64'(resp_fail_o), 64'd0);
    @(posedge clk); #1;
    resp_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
